// File: rtl/bot_upd_ctrl.sv
// Rojobot update handshake: snapshots bot_info on an update edge, holds it for the CPU
// until acknowledged, defers one update that arrives during release, and counts the rest as misses.
module bot_upd_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MISS_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_sysregs,
    input  logic [31:0]       bot_info_in,
    input  logic              int_ack,
    input  logic              clr_status,
    output logic              bot_update_sync,
    output logic [31:0]       bot_info_out,
    output logic [MISS_W-1:0] miss_cnt,
    output logic              timeout_flag,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               upd_q_reg;
    logic               arm_reg;
    logic               deferred_reg, deferred_next;
    logic [CNT_W-1:0]   tmo_cnt_reg;
    logic [31:0]        info_reg;
    logic [MISS_W-1:0]  miss_reg;
    logic               tmo_flag_reg;

    logic               evt;
    logic               capture;
    logic               miss_inc;
    logic               tmo_hit;

    // arm_reg blocks the first post-reset edge, where upd_q does not yet hold a real sample
    assign evt = arm_reg & upd_sysregs & ~upd_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        deferred_next = deferred_reg;
        capture       = 1'b0;
        miss_inc      = 1'b0;
        tmo_hit       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (evt) begin
                    capture    = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (int_ack) begin
                    // an update racing the acknowledge is kept for after release
                    state_next = RELEASE;
                    if (evt) deferred_next = 1'b1;
                end else begin
                    if (evt) miss_inc = 1'b1;
                    if (tmo_cnt_reg == TMO_LAST) begin
                        tmo_hit    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RELEASE: begin
                if (!int_ack) begin
                    deferred_next = 1'b0;
                    if (deferred_reg || evt) begin
                        capture    = 1'b1;
                        state_next = PEND;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (evt) begin
                    if (deferred_reg) miss_inc = 1'b1;
                    else              deferred_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bot_update_sync = (state_reg == PEND);
        busy            = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_q_reg    <= 1'b0;
            arm_reg      <= 1'b0;
            deferred_reg <= 1'b0;
            tmo_cnt_reg  <= '0;
            info_reg     <= '0;
            miss_reg     <= '0;
            tmo_flag_reg <= 1'b0;
        end else begin
            upd_q_reg    <= upd_sysregs;
            arm_reg      <= 1'b1;
            deferred_reg <= deferred_next;
            if (state_reg == PEND && state_next == PEND) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end else begin
                tmo_cnt_reg <= '0;
            end
            if (capture) begin
                info_reg <= bot_info_in;
            end
            if (clr_status) begin
                miss_reg     <= '0;
                tmo_flag_reg <= 1'b0;
            end else begin
                if (miss_inc && miss_reg != MISS_MAX) miss_reg <= miss_reg + 1'b1;
                if (tmo_hit) tmo_flag_reg <= 1'b1;
            end
        end
    end

    assign bot_info_out = info_reg;
    assign miss_cnt     = miss_reg;
    assign timeout_flag = tmo_flag_reg;

endmodule
